// File: rtl/csc_pack_if.sv
// Stream bundle between the colour-space-conversion matrix stage and csc_pack:
// three lockstep component inputs (y0..y2) plus the serialized output (z).
interface csc_pack_if #(
  parameter int W = 16
);
  logic [W-1:0] y0;
  logic [3:0]   y0_mflags;
  logic [1:0]   y0_sflags;
  logic [W-1:0] y1;
  logic [3:0]   y1_mflags;
  logic [1:0]   y1_sflags;
  logic [W-1:0] y2;
  logic [3:0]   y2_mflags;
  logic [1:0]   y2_sflags;
  logic [W-1:0] z;
  logic [3:0]   z_mflags;
  logic [1:0]   z_sflags;
  logic [1:0]   z_lane;

  // Packer view: sink of the three component lanes, source of z.
  modport slave (
    input  y0, y0_mflags, y1, y1_mflags, y2, y2_mflags, z_sflags,
    output y0_sflags, y1_sflags, y2_sflags, z, z_mflags, z_lane
  );

  // Environment view: drives the component lanes, consumes z.
  modport master (
    output y0, y0_mflags, y1, y1_mflags, y2, y2_mflags, z_sflags,
    input  y0_sflags, y1_sflags, y2_sflags, z, z_mflags, z_lane
  );
endinterface

// File: rtl/csc_pack.sv
// csc_pack: collects complete {y0,y1,y2} triplets into a small FIFO and
// serializes each triplet onto a single W-bit lane in component order 0,1,2.
module csc_pack #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  csc_pack_if.slave   bus,
  output logic        err_misalign
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] PH0 = 2'd0;
  localparam logic [1:0] PH1 = 2'd1;
  localparam logic [1:0] PH2 = 2'd2;

  typedef struct packed {
    logic [W-1:0] c0;
    logic [W-1:0] c1;
    logic [W-1:0] c2;
    logic         sop;
    logic         eop;
    logic         user;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [1:0]    r_phase;
  logic          r_err;

  logic          w_stall;
  logic          w_afull;
  logic [1:0]    w_sflags;
  logic          w_all_valid;
  logic          w_push;
  logic [2:0]    w_sop_bits;
  logic [2:0]    w_eop_bits;
  logic          w_mismatch;
  logic          w_nonempty;
  logic          w_xfer;
  logic          w_pop;
  entry_t        w_head;
  logic [W-1:0]  w_z;
  logic [3:0]    w_z_mflags;
  logic [1:0]    w_z_lane;
  logic          w_unused;

  // Input-side back-pressure depends only on registered occupancy.
  assign w_stall  = (r_count == CW'(DEPTH));
  assign w_afull  = (r_count >= CW'(DEPTH - 1));
  assign w_sflags = {w_afull, w_stall};

  assign bus.y0_sflags = w_sflags;
  assign bus.y1_sflags = w_sflags;
  assign bus.y2_sflags = w_sflags;

  // A triplet is accepted only when all three lanes are valid together.
  assign w_all_valid = bus.y0_mflags[0] & bus.y1_mflags[0] & bus.y2_mflags[0];
  assign w_push      = w_all_valid & ~w_stall;

  assign w_sop_bits = {bus.y2_mflags[1], bus.y1_mflags[1], bus.y0_mflags[1]};
  assign w_eop_bits = {bus.y2_mflags[2], bus.y1_mflags[2], bus.y0_mflags[2]};
  assign w_mismatch = ((w_sop_bits != 3'b000) && (w_sop_bits != 3'b111)) ||
                      ((w_eop_bits != 3'b000) && (w_eop_bits != 3'b111));

  assign w_nonempty = (r_count != '0);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_xfer     = w_nonempty & ~bus.z_sflags[0];
  assign w_pop      = w_xfer & (r_phase == PH2);

  // Lanes 1/2 user bits and the consumer's almost_full carry no meaning here.
  assign w_unused = ^{bus.z_sflags[1], bus.y1_mflags[3], bus.y2_mflags[3]};

  // Select the head component for the current phase and decorate it with flags.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_z        = '0;
    w_z_mflags = '0;
    w_z_lane   = '0;
    if (w_nonempty) begin
      w_z_mflags[0] = 1'b1;
      w_z_mflags[3] = w_head.user;
      w_z_lane      = r_phase;
      case (r_phase)
        PH0: begin
          w_z           = w_head.c0;
          w_z_mflags[1] = w_head.sop;
        end
        PH1: w_z = w_head.c1;
        PH2: begin
          w_z           = w_head.c2;
          w_z_mflags[2] = w_head.eop;
        end
        default: w_z = w_head.c0;
      endcase
    end
  end

  assign bus.z        = w_z;
  assign bus.z_mflags = w_z_mflags;
  assign bus.z_lane   = w_z_lane;
  assign err_misalign = r_err;

  // Triplet storage; lane 0 supplies the framing flags.
  // NOTE: the storage array has no reset; occupancy gates every read, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{c0:   bus.y0,
                           c1:   bus.y1,
                           c2:   bus.y2,
                           sop:  bus.y0_mflags[1],
                           eop:  bus.y0_mflags[2],
                           user: bus.y0_mflags[3]};
    end
  end

  // FIFO pointers and occupancy; both pointers wrap modulo DEPTH.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Serializer phase advances on each accepted output word and wraps on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= PH0;
    end else if (w_xfer) begin
      case (r_phase)
        PH0:     r_phase <= PH1;
        PH1:     r_phase <= PH2;
        default: r_phase <= PH0;
      endcase
    end
  end

  // Sticky misalignment flag, raised when a pushed triplet disagrees on framing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_push && w_mismatch) begin
      r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_csc_pack.sv
// Self-checking bench for csc_pack: a directed vector table, hand sequences for
// burst / misalignment / reset corners, and random traffic against a queue model.
module tb_csc_pack;
  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic err_misalign;

  csc_pack_if #(.W(W)) bus ();

  csc_pack #(.W(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .err_misalign (err_misalign)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [2:0]  v;
    logic [15:0] d0, d1, d2;
    logic [2:0]  sop, eop;
    logic        user;
    logic        zst;
    logic        zv;
    logic [15:0] z;
    logic [1:0]  lane;
    logic        s, e, u;
  } vec_t;

  typedef struct packed {
    logic [2:0][15:0] c;
    logic             sop;
    logic             eop;
    logic             user;
  } trip_t;

  // Reference model: queue of whole triplets plus the index of the next word.
  trip_t mq[$];
  int    mword;
  logic  merr;

  vec_t  tbl [20];
  logic  dmy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic zv, input logic [15:0] z,
                            input logic [1:0] lane, input logic s, input logic e,
                            input logic u, input logic [1:0] sfl, input logic err);
    check({tag, ".z_mflags"}, 32'(bus.z_mflags), 32'({u, e, s, zv}));
    check({tag, ".z"}, 32'(bus.z), 32'(z));
    check({tag, ".z_lane"}, 32'(bus.z_lane), 32'(lane));
    check({tag, ".y0_sflags"}, 32'(bus.y0_sflags), 32'(sfl));
    check({tag, ".y1_sflags"}, 32'(bus.y1_sflags), 32'(sfl));
    check({tag, ".y2_sflags"}, 32'(bus.y2_sflags), 32'(sfl));
    check({tag, ".err"}, 32'(err_misalign), 32'(err));
  endtask

  task automatic drive(input logic [2:0] v, input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [2:0] sop, input logic [2:0] eop,
                       input logic user, input logic zst);
    bus.y0        = d0;
    bus.y1        = d1;
    bus.y2        = d2;
    bus.y0_mflags = {user, eop[0], sop[0], v[0]};
    bus.y1_mflags = {user, eop[1], sop[1], v[1]};
    bus.y2_mflags = {user, eop[2], sop[2], v[2]};
    bus.z_sflags  = {1'($urandom_range(0, 1)), zst};
  endtask

  function automatic vec_t mk(logic [2:0] v, logic [15:0] d0, logic [15:0] d1, logic [15:0] d2,
                              logic [2:0] sop, logic [2:0] eop, logic user, logic zst,
                              logic zv, logic [15:0] z, logic [1:0] lane,
                              logic s, logic e, logic u);
    vec_t r;
    r.v = v; r.d0 = d0; r.d1 = d1; r.d2 = d2; r.sop = sop; r.eop = eop;
    r.user = user; r.zst = zst; r.zv = zv; r.z = z; r.lane = lane;
    r.s = s; r.e = e; r.u = u;
    return r;
  endfunction

  task automatic model_clear();
    mq.delete();
    mword = 0;
    merr  = 1'b0;
  endtask

  // One cycle: compare DUT against the model, drive inputs, advance the model.
  task automatic step(input logic [2:0] v, input logic [15:0] d0, input logic [15:0] d1,
                      input logic [15:0] d2, input logic [2:0] sop, input logic [2:0] eop,
                      input logic user, input logic zst, output logic acc);
    int    occ;
    logic  ev;
    trip_t h;
    @(negedge clk);
    occ = mq.size();
    ev  = (occ != 0);
    h   = ev ? mq[0] : '0;
    check_outs("mdl", ev, ev ? h.c[mword] : 16'h0, ev ? 2'(mword) : 2'd0,
               ev && (mword == 0) && h.sop, ev && (mword == 2) && h.eop, ev && h.user,
               {(occ >= DEPTH - 1), (occ == DEPTH)}, merr);
    drive(v, d0, d1, d2, sop, eop, user, zst);
    acc = (v == 3'b111) && (occ < DEPTH);
    if (ev && !zst) begin
      if (mword == 2) begin
        void'(mq.pop_front());
        mword = 0;
      end else begin
        mword++;
      end
    end
    if (acc) begin
      mq.push_back({{d2, d1, d0}, sop[0], eop[0], user});
      if ((sop != 3'b000 && sop != 3'b111) || (eop != 3'b000 && eop != 3'b111)) merr = 1'b1;
    end
  endtask

  task automatic idle(input logic zst);
    step(3'b000, 16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 1'b0, zst, dmy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(3'b000, 16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_outs("rst", 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k, first, last, st_cyc, af_cyc;
    logic       acc;
    logic [15:0] words[$];
    logic [2:0] v, sop, eop;
    logic       s, e;

    rst_n = 1'b0;
    model_clear();
    do_reset();

    // Directed table: single triplet, 5-cycle output stall in PH1, lane skew.
    tbl[0]  = mk(3'b111, 16'h0011, 16'h0022, 16'h0033, 3'b111, 3'b111, 0, 0,  0, 16'h0, 0, 0, 0, 0);
    tbl[1]  = mk(3'b000, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0,  1, 16'h0011, 0, 1, 0, 0);
    tbl[2]  = mk(3'b000, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0,  1, 16'h0022, 1, 0, 0, 0);
    tbl[3]  = mk(3'b000, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0,  1, 16'h0033, 2, 0, 1, 0);
    tbl[4]  = mk(3'b111, 16'h00AA, 16'h00BB, 16'h00CC, 0, 0, 1, 0,  0, 16'h0, 0, 0, 0, 0);
    tbl[5]  = mk(3'b000, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0,  1, 16'h00AA, 0, 0, 0, 1);
    for (int i = 6; i <= 10; i++)
      tbl[i] = mk(3'b000, 16'h0, 16'h0, 16'h0, 0, 0, 0, 1,  1, 16'h00BB, 1, 0, 0, 1);
    tbl[11] = mk(3'b000, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0,  1, 16'h00BB, 1, 0, 0, 1);
    tbl[12] = mk(3'b000, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0,  1, 16'h00CC, 2, 0, 0, 1);
    tbl[13] = mk(3'b101, 16'h0101, 16'h0202, 16'h0303, 3'b111, 3'b111, 0, 0,  0, 16'h0, 0, 0, 0, 0);
    tbl[14] = mk(3'b101, 16'h0101, 16'h0202, 16'h0303, 3'b111, 3'b111, 0, 0,  0, 16'h0, 0, 0, 0, 0);
    tbl[15] = mk(3'b111, 16'h0101, 16'h0202, 16'h0303, 3'b111, 3'b111, 0, 0,  0, 16'h0, 0, 0, 0, 0);
    tbl[16] = mk(3'b000, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0,  1, 16'h0101, 0, 1, 0, 0);
    tbl[17] = mk(3'b000, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0,  1, 16'h0202, 1, 0, 0, 0);
    tbl[18] = mk(3'b000, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0,  1, 16'h0303, 2, 0, 1, 0);
    tbl[19] = mk(3'b000, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0,  0, 16'h0, 0, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_outs($sformatf("tbl%0d", i), tbl[i].zv, tbl[i].z, tbl[i].lane,
                 tbl[i].s, tbl[i].e, tbl[i].u, 2'b00, 1'b0);
      drive(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].sop, tbl[i].eop,
            tbl[i].user, tbl[i].zst);
    end

    // Burst: 8 back-to-back triplets, consumer never stalls.
    do_reset();
    k = 0; first = -1; last = -1; st_cyc = -1; af_cyc = -1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (k < 8)
        step(3'b111, 16'(k * 16), 16'(k * 16 + 1), 16'(k * 16 + 2),
             {3{k == 0}}, {3{k == 7}}, 1'b0, 1'b0, acc);
      else
        step(3'b000, 16'h0, 16'h0, 16'h0, 3'b000, 3'b000, 1'b0, 1'b0, acc);
      if (acc) k++;
      if (bus.z_mflags[0]) begin
        words.push_back(bus.z);
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (bus.y0_sflags[0] && st_cyc < 0) st_cyc = cyc;
      if (bus.y0_sflags[1] && af_cyc < 0) af_cyc = cyc;
    end
    check("burst.word_count", 32'(words.size()), 32'd24);
    for (int j = 0; j < words.size() && j < 24; j++)
      check($sformatf("burst.word%0d", j), 32'(words[j]), 32'((j / 3) * 16 + (j % 3)));
    check("burst.no_gaps", 32'(last - first + 1), 32'd24);
    check("burst.stall_seen", 32'(st_cyc >= 0), 32'd1);
    check("burst.afull_before_stall", 32'(af_cyc >= 0 && af_cyc < st_cyc), 32'd1);

    // Flag mismatch: lane 1 disagrees on sop; output framing follows lane 0.
    step(3'b111, 16'h0A0A, 16'h0B0B, 16'h0C0C, 3'b101, 3'b111, 1'b0, 1'b0, dmy);
    repeat (5) idle(1'b0);
    check("mis.err_sticky", 32'(err_misalign), 32'd1);

    // Reset during PH1 with three triplets buffered.
    step(3'b111, 16'h1111, 16'h1112, 16'h1113, 3'b111, 3'b000, 1'b0, 1'b1, dmy);
    step(3'b111, 16'h2221, 16'h2222, 16'h2223, 3'b000, 3'b000, 1'b0, 1'b0, dmy);
    step(3'b111, 16'h3331, 16'h3332, 16'h3333, 3'b000, 3'b111, 1'b0, 1'b1, dmy);
    idle(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 16'h0, 2'd0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    repeat (4) idle(1'b0);
    step(3'b111, 16'h4441, 16'h4442, 16'h4443, 3'b111, 3'b111, 1'b1, 1'b0, dmy);
    repeat (4) idle(1'b0);

    // Random traffic: mostly aligned triplets, occasional skew and flag mismatch.
    for (int i = 0; i < 1500; i++) begin
      v   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      s   = 1'($urandom);
      e   = 1'($urandom);
      sop = ($urandom_range(0, 31) == 0) ? 3'($urandom) : {3{s}};
      eop = ($urandom_range(0, 31) == 0) ? 3'($urandom) : {3{e}};
      step(v, 16'($urandom), 16'($urandom), 16'($urandom), sop, eop,
           1'($urandom), ($urandom_range(0, 3) == 0), dmy);
    end
    repeat (20) idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
